// File: rtl/dcache_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_mem_if
// Description : MEM-stage request/response, flush and data-RAM signal bundle
//               for the direct-mapped data cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        flush;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  req_valid, req_load, req_store, req_size, req_sign,
        input  req_addr, req_wdata, flush, dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dm_addr, dm_wen, dm_wdata, hit_cnt, miss_cnt
    );

    modport master (
        output req_valid, req_load, req_store, req_size, req_sign,
        output req_addr, req_wdata, flush, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dm_addr, dm_wen, dm_wdata, hit_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dcache_mem.sv
`default_nettype none
// ============================================================================
// Module      : dcache_mem
// Description : Direct-mapped, write-through, one-word-per-line data cache
//               with flush sweep and load hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_mem #(
    parameter int INDEX_BITS = 5
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dcache_mem_if.slave   bus
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MISS  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  pend_q;
    logic [INDEX_BITS-1:0] fl_idx_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [31:0]           data_q [LINES];

    logic [1:0]            miss_off_q;
    logic [1:0]            miss_size_q;
    logic                  miss_sign_q;
    logic [INDEX_BITS-1:0] miss_idx_q;
    logic [TAG_BITS-1:0]   miss_tag_q;

    logic                  resp_valid_q, resp_err_q;
    logic [31:0]           resp_rdata_q;
    logic [31:0]           hit_cnt_q, miss_cnt_q;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit, w_misalign, w_ready, w_accept;
    logic [3:0]            w_be, w_dm_wen;
    logic [31:0]           w_lanes, w_merged;
    logic                  w_line_we;
    logic [INDEX_BITS-1:0] w_line_idx;
    logic [TAG_BITS-1:0]   w_line_tag;
    logic [31:0]           w_line_data;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = {{24{sg & b[7]}}, b};
            2'b01:   extract = {{16{sg & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    assign w_idx      = bus.req_addr[INDEX_BITS+1:2];
    assign w_tag      = bus.req_addr[31:INDEX_BITS+2];
    assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_lanes = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_be    = 4'b0001 << bus.req_addr[1:0];
                w_lanes = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
        w_merged = data_q[w_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) w_merged[8*b +: 8] = w_lanes[8*b +: 8];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a flush request outranks a same-cycle access
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.flush || pend_q)
                    state_d = S_FLUSH;
                else if (w_accept && bus.req_load && !w_misalign && !w_hit)
                    state_d = S_MISS;
            end
            S_MISS:  state_d = S_IDLE;
            S_FLUSH: if (&fl_idx_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_ready  = (state_q == S_IDLE) && !bus.flush && !pend_q && !reset;
        w_accept = bus.req_valid && w_ready;
        w_dm_wen = (w_accept && !bus.req_load && bus.req_store && !w_misalign) ? w_be : 4'b0000;
    end

    // Line writes: miss fill, store-hit merge, or word-store allocate
    always_comb begin
        w_line_we   = 1'b0;
        w_line_idx  = w_idx;
        w_line_tag  = w_tag;
        w_line_data = w_lanes;
        if (state_q == S_MISS) begin
            w_line_we   = 1'b1;
            w_line_idx  = miss_idx_q;
            w_line_tag  = miss_tag_q;
            w_line_data = bus.dm_rdata;
        end else if (w_dm_wen != 4'b0000) begin
            if (w_hit) begin
                w_line_we   = 1'b1;
                w_line_data = w_merged;
            end else if (w_be == 4'b1111) begin
                w_line_we   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_line_we) begin
            tag_q[w_line_idx]  <= w_line_tag;
            data_q[w_line_idx] <= w_line_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            pend_q       <= 1'b0;
            fl_idx_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            hit_cnt_q    <= 32'd0;
            miss_cnt_q   <= 32'd0;
            miss_off_q   <= 2'b00;
            miss_size_q  <= 2'b00;
            miss_sign_q  <= 1'b0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            if (state_q == S_MISS && bus.flush) pend_q <= 1'b1;
            if (state_q == S_IDLE && state_d == S_FLUSH) begin
                pend_q   <= 1'b0;
                fl_idx_q <= '0;
            end
            if (state_q == S_FLUSH) begin
                valid_q[fl_idx_q] <= 1'b0;
                fl_idx_q          <= fl_idx_q + {{(INDEX_BITS-1){1'b0}}, 1'b1};
            end
            if (w_line_we) valid_q[w_line_idx] <= 1'b1;
            if (state_q == S_MISS) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= extract(bus.dm_rdata, miss_off_q, miss_size_q, miss_sign_q);
            end
            if (w_accept) begin
                if (w_misalign) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= 32'd0;
                end else if (bus.req_load) begin
                    if (w_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= extract(data_q[w_idx], bus.req_addr[1:0],
                                                bus.req_size, bus.req_sign);
                        hit_cnt_q    <= hit_cnt_q + 32'd1;
                    end else begin
                        miss_cnt_q  <= miss_cnt_q + 32'd1;
                        miss_off_q  <= bus.req_addr[1:0];
                        miss_size_q <= bus.req_size;
                        miss_sign_q <= bus.req_sign;
                        miss_idx_q  <= w_idx;
                        miss_tag_q  <= w_tag;
                    end
                end else begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'd0;
                end
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.dm_addr    = {bus.req_addr[31:2], 2'b00};
    assign bus.dm_wen     = w_dm_wen;
    assign bus.dm_wdata   = w_lanes;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
endmodule
`default_nettype wire
